// File: rtl/sdi_line_crc_ctrl_if.sv
// SDI line CRC controller bus: input word stream, output word stream and line status.
interface sdi_line_crc_ctrl_if;
  logic [9:0]  din;
  logic        din_valid;
  logic [9:0]  dout;
  logic        dout_valid;
  logic [10:0] line_num;
  logic        line_done;
  logic        crc_err;
  logic        sync_err;

  modport master (
    output din, din_valid,
    input  dout, dout_valid, line_num, line_done, crc_err, sync_err
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_valid, line_num, line_done, crc_err, sync_err
  );
endinterface

// File: rtl/sdi_line_crc_ctrl.sv
// SDI per-channel line CRC: tracks TRS/line structure, accumulates the 18-bit line CRC,
// checks (and optionally replaces) CR0/CR1, decodes LN0/LN1. One-cycle registered latency.
module sdi_line_crc_ctrl #(
  parameter bit INSERT_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  sdi_line_crc_ctrl_if.slave sdi
);

  typedef enum logic [2:0] {StSearch, StActive, StLn0, StLn1, StCr0, StCr1} state_e;

  // x^18 + x^5 + x^4 + 1, LSB-first: reflected feedback mask hits bits 17, 13, 12.
  localparam logic [17:0] CrcMask = 18'h23000;

  function automatic logic [17:0] crc_step(input logic [17:0] c, input logic [9:0] d);
    logic [17:0] r;
    r = c;
    for (int b = 0; b < 10; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ CrcMask;
      else             r = r >> 1;
    end
    return r;
  endfunction

  state_e      r_state, w_state_d;
  logic [1:0]  r_trs_cnt, w_trs_cnt_d;
  logic [17:0] r_crc, w_crc_d;
  logic [9:0]  r_ln0, w_ln0_d;
  logic        r_cr0_bad, w_cr0_bad_d;
  logic [9:0]  r_dout, w_dout_d;
  logic        r_dout_valid;
  logic [10:0] r_line_num, w_line_num_d;
  logic        r_line_done, w_line_done_d;
  logic        r_crc_err, w_crc_err_d;
  logic        r_sync_err, w_sync_err_d;

  logic        w_sav, w_eav;
  logic [17:0] w_crc_acc;
  logic [9:0]  w_cr0_word, w_cr1_word;

  // r_trs_cnt counts matched words of 3FF,000,000; at 3 the current word is XYZ.
  assign w_sav      = sdi.din_valid && (r_trs_cnt == 2'd3) && !sdi.din[6];
  assign w_eav      = sdi.din_valid && (r_trs_cnt == 2'd3) && sdi.din[6];
  assign w_crc_acc  = crc_step(r_crc, sdi.din);
  assign w_cr0_word = {~r_crc[8], r_crc[8:0]};
  assign w_cr1_word = {~r_crc[17], r_crc[17:9]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StSearch;
    else     r_state <= w_state_d;
  end

  // Next state: advances only on valid words; SAV always restarts the line.
  always_comb begin
    w_state_d = r_state;
    if (sdi.din_valid) begin
      if (w_sav) begin
        w_state_d = StActive;
      end else begin
        case (r_state)
          StSearch: w_state_d = StSearch;
          StActive: if (w_eav) w_state_d = StLn0;
          StLn0:    w_state_d = StLn1;
          StLn1:    w_state_d = StCr0;
          StCr0:    w_state_d = StCr1;
          StCr1:    w_state_d = StSearch;
          default:  w_state_d = StSearch;
        endcase
      end
    end
  end

  // Outputs and datapath next values; everything holds while din_valid is low.
  always_comb begin
    w_trs_cnt_d   = r_trs_cnt;
    w_crc_d       = r_crc;
    w_ln0_d       = r_ln0;
    w_cr0_bad_d   = r_cr0_bad;
    w_line_num_d  = r_line_num;
    w_dout_d      = sdi.din;
    w_line_done_d = 1'b0;
    w_crc_err_d   = 1'b0;
    w_sync_err_d  = 1'b0;
    if (sdi.din_valid) begin
      // A 3FF anywhere restarts the pattern as its first word.
      if (sdi.din == 10'h3FF)                               w_trs_cnt_d = 2'd1;
      else if (sdi.din == 10'h000 && r_trs_cnt inside {2'd1, 2'd2}) w_trs_cnt_d = r_trs_cnt + 2'd1;
      else                                                  w_trs_cnt_d = 2'd0;

      if (w_sav) begin
        w_crc_d      = '0;
        w_sync_err_d = (r_state != StSearch);
      end else begin
        case (r_state)
          StSearch: w_sync_err_d = w_eav;
          StActive: w_crc_d = w_crc_acc;
          StLn0: begin
            w_crc_d = w_crc_acc;
            w_ln0_d = sdi.din;
          end
          StLn1: begin
            w_crc_d      = w_crc_acc;
            w_line_num_d = {sdi.din[5:2], r_ln0[8:2]};
          end
          StCr0: begin
            w_cr0_bad_d = (sdi.din != w_cr0_word);
            if (INSERT_EN) w_dout_d = w_cr0_word;
          end
          StCr1: begin
            w_line_done_d = 1'b1;
            w_crc_err_d   = r_cr0_bad || (sdi.din != w_cr1_word);
            if (INSERT_EN) w_dout_d = w_cr1_word;
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trs_cnt    <= '0;
      r_crc        <= '0;
      r_ln0        <= '0;
      r_cr0_bad    <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_line_num   <= '0;
      r_line_done  <= 1'b0;
      r_crc_err    <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_trs_cnt    <= w_trs_cnt_d;
      r_crc        <= w_crc_d;
      r_ln0        <= w_ln0_d;
      r_cr0_bad    <= w_cr0_bad_d;
      r_dout       <= w_dout_d;
      r_dout_valid <= sdi.din_valid;
      r_line_num   <= w_line_num_d;
      r_line_done  <= w_line_done_d;
      r_crc_err    <= w_crc_err_d;
      r_sync_err   <= w_sync_err_d;
    end
  end

  assign sdi.dout       = r_dout;
  assign sdi.dout_valid = r_dout_valid;
  assign sdi.line_num   = r_line_num;
  assign sdi.line_done  = r_line_done;
  assign sdi.crc_err    = r_crc_err;
  assign sdi.sync_err   = r_sync_err;

endmodule

// File: doc/sdi_line_crc_ctrl.md
SDI_LINE_CRC_CTRL -- requirements
Module: sdi_line_crc_ctrl

Interface
REQ-001 Parameter: INSERT_EN, 1, 1 = replace CR0/CR1 words on output with computed CRC; 0 = pass input words unchanged.
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: din  in  10  one channel (Y or C) of the 10-bit SDI word stream.
REQ-005 Port: din_valid  in  1  din qualifier; invalid cycles are ignored (stall).
REQ-006 Port: dout  out  10  output word stream.
REQ-007 Port: dout_valid  out  1  dout qualifier.
REQ-008 Port: line_num  out  11  line number decoded from LN0/LN1.
REQ-009 Port: line_done  out  1  one-cycle pulse after CR1 is processed.
REQ-010 Port: crc_err  out  1  one-cycle pulse, asserted together with line_done when received CR0/CR1 differ from the computed CRC.
REQ-011 Port: sync_err  out  1  one-cycle pulse on sequence violation.

Function
REQ-012 CRC: 18-bit, polynomial x^18+x^5+x^4+1, right-shift (LSB-first), one 10-bit word per valid cycle; register cleared to 0 at each SAV.
REQ-013 CRC coverage: first word after SAV XYZ through LN1 inclusive, including the EAV words 3FF/000/000/XYZ.
REQ-014 TRS detection: three consecutive valid words 3FF, 000, 000; the next valid word is XYZ; XYZ bit 6 = 1 -> EAV, 0 -> SAV.
REQ-015 States: SEARCH, ACTIVE, LN0, LN1, CR0, CR1.
REQ-016 SEARCH: CRC frozen; SAV detected -> ACTIVE, CRC cleared.
REQ-017 ACTIVE: every valid word accumulates into the CRC; EAV XYZ accumulates, then -> LN0.
REQ-018 LN0, then LN1: each accumulates and advances; at LN1, line_num <= {LN1[5:2], LN0[8:2]}.
REQ-019 CR0: dout = {~crc[8], crc[8:0]} when INSERT_EN = 1; received word is compared with the same value; -> CR1.
REQ-020 CR1: dout = {~crc[17], crc[17:9]} when INSERT_EN = 1; received word is compared; -> SEARCH; line_done pulses; crc_err pulses if either compare failed.
REQ-021 SAV detected in any state other than SEARCH: sync_err pulses; CRC cleared; -> ACTIVE; no line_done.
REQ-022 EAV detected in SEARCH: sync_err pulses; state remains SEARCH.
REQ-023 Latency: exactly 1 clk from din/din_valid to dout/dout_valid; dout_valid equals din_valid delayed by 1.
REQ-024 din_valid = 0: state, CRC and TRS-detector history hold; no pulses are generated.
REQ-025 TRS detector runs in every state and restarts on any mismatch; a 3FF mid-pattern counts as a new first word.
REQ-026 Non-CR words are passed unchanged.

Reset
REQ-027 rst asserted: state = SEARCH; CRC = 0; TRS history cleared; dout = 0; dout_valid = 0; line_num = 0; all pulses = 0.
REQ-028 rst deasserted mid-line: no insertion and no line_done until the next SAV.

Verification
REQ-029 Reset: rst high mid-ACTIVE -> dout_valid = 0, line_num = 0 next cycle; after release, first EAV -> sync_err = 1, no CR insertion.
REQ-030 Nominal line: SAV (XYZ=200), 1920 ramp words, EAV (XYZ=274), LN0/LN1 encoding line 42, CR0/CR1 = 000/000 -> dout CR0/CR1 match bench CRC model; line_num = 42; line_done = 1; crc_err = 1.
REQ-031 Correct CR words: same line with CR0/CR1 set from the bench model -> crc_err = 0, line_done = 1, stream bit-exact through.
REQ-032 Stalls: same line with din_valid randomly low 30% -> identical dout word sequence and CRC to REQ-031.
REQ-033 Truncated line: SAV, 100 words, second SAV -> sync_err = 1, no line_done; next full line checks clean.
REQ-034 INSERT_EN = 0: wrong CR0/CR1 input -> dout carries received words unchanged; crc_err = 1.
